// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong geometry defaults, game-state enum, direction encoding
// and the score increment helper used by ball_engine.
package pong_pkg;

    localparam int unsigned PONG_SCREEN_W   = 640;
    localparam int unsigned PONG_SCREEN_H   = 480;
    localparam int unsigned PONG_BALL_SIZE  = 8;
    localparam int unsigned PONG_PADDLE_W   = 8;
    localparam int unsigned PONG_PADDLE_H   = 50;
    localparam int unsigned PONG_P1_X       = 40;
    localparam int unsigned PONG_P2_X       = 600;
    localparam int unsigned PONG_SPD_X      = 8;
    localparam int unsigned PONG_SPD_Y      = 4;
    localparam int unsigned PONG_SERVE_GAP  = 25;
    localparam int unsigned PONG_HOLD_FRAMES = 30;
    localparam int unsigned PONG_WIN_SCORE  = 9;

    typedef enum logic [2:0] {
        SERVE_L,
        SERVE_R,
        PLAY,
        SCORED,
        GAME_OVER
    } game_state_t;

    // DIR_NEG is left / up, DIR_POS is right / down.
    typedef enum logic {
        DIR_NEG = 1'b0,
        DIR_POS = 1'b1
    } dir_t;

    function automatic logic [3:0] score_inc(input logic [3:0] s);
        return (s >= 4'd9) ? 4'd9 : s + 4'd1;
    endfunction

endpackage

// File: rtl/ball_paddle_hit.sv
// ball_paddle_hit: box-overlap test of a candidate ball square against one
// paddle rectangle, plus whether the ball centre sits above the paddle centre.
module ball_paddle_hit #(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PADDLE_W  = 8,
    parameter int unsigned PADDLE_H  = 50
) (
    input  logic [10:0] cand_x,
    input  logic [10:0] cand_y,
    input  logic [10:0] pad_x,
    input  logic [10:0] pad_y,
    output logic        hit,
    output logic        upper_half
);

    localparam logic [10:0] BS   = 11'(BALL_SIZE);
    localparam logic [10:0] PW   = 11'(PADDLE_W);
    localparam logic [10:0] PH   = 11'(PADDLE_H);
    localparam logic [10:0] BS_2 = 11'(BALL_SIZE / 2);
    localparam logic [10:0] PH_2 = 11'(PADDLE_H / 2);

    always_comb begin
        hit = (cand_x < pad_x + PW) && (cand_x + BS > pad_x) &&
              (cand_y < pad_y + PH) && (cand_y + BS > pad_y);
        upper_half = (cand_y + BS_2) < (pad_y + PH_2);
    end

endmodule

// File: rtl/ball_engine.sv
// ball_engine: frame-rate Pong engine (ball motion, serve/score FSM, scores).
// Optional BALL_SPEEDUP_EN macro adds per-rally horizontal speed-up on paddle hits.
module ball_engine
    import pong_pkg::*;
#(
    parameter int unsigned SCREEN_W    = PONG_SCREEN_W,
    parameter int unsigned SCREEN_H    = PONG_SCREEN_H,
    parameter int unsigned BALL_SIZE   = PONG_BALL_SIZE,
    parameter int unsigned PADDLE_W    = PONG_PADDLE_W,
    parameter int unsigned PADDLE_H    = PONG_PADDLE_H,
    parameter int unsigned P1_X        = PONG_P1_X,
    parameter int unsigned P2_X        = PONG_P2_X,
    parameter int unsigned SPD_X       = PONG_SPD_X,
    parameter int unsigned SPD_Y       = PONG_SPD_Y,
    parameter int unsigned SERVE_GAP   = PONG_SERVE_GAP,
    parameter int unsigned HOLD_FRAMES = PONG_HOLD_FRAMES,
    parameter int unsigned WIN_SCORE   = PONG_WIN_SCORE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       p1_srv,
    input  logic       p2_srv,
    input  logic [8:0] p1_y,
    input  logic [8:0] p2_y,
    output logic [9:0] ball_x,
    output logic [8:0] ball_y,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       serving,
    output logic       game_over,
    output logic       point_p1,
    output logic       point_p2
);

    localparam logic [10:0] X_MAX     = 11'(SCREEN_W - BALL_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0] SPX       = 11'(SPD_X);
    localparam logic [10:0] SPY       = 11'(SPD_Y);
    localparam logic [10:0] P1X       = 11'(P1_X);
    localparam logic [10:0] P2X       = 11'(P2_X);
    localparam logic [10:0] P1_FACE   = 11'(P1_X + PADDLE_W);
    localparam logic [10:0] P2_FACE   = 11'(P2_X - BALL_SIZE);
    localparam logic [10:0] SRV_OFS   = 11'((PADDLE_H - BALL_SIZE) / 2);
    localparam logic [9:0]  SRV_L_X   = 10'(P1_X + SERVE_GAP);
    localparam logic [9:0]  SRV_R_X   = 10'(P2_X - SERVE_GAP);
    localparam logic [8:0]  Y_RST     = 9'(SCREEN_H / 2);
    localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0]  WIN       = 4'(WIN_SCORE);

    game_state_t state;
    dir_t        dx, dy;
    logic [7:0]  hold_cnt;
    logic        p2_scored;

    logic [10:0] cx, cy, cand_l, cand_r, nx, ny, sy_l, sy_r;
    dir_t        ndx, ndy;
    logic        hit_l, hit_r, up_l, up_r;
    logic        miss_l, miss_r, paddle_hit;
    logic [10:0] spd_x;

`ifdef BALL_SPEEDUP_EN
    localparam logic [10:0] SPX_MAX = 11'(2 * SPD_X);
    logic [1:0] hit_cnt;

    // Every fourth hit of a rally (counter wrapping 3->0) bumps the speed.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt <= '0;
            spd_x   <= SPX;
        end else if (state == PLAY && frame_tick) begin
            if (miss_l || miss_r) begin
                hit_cnt <= '0;
                spd_x   <= SPX;
            end else if (paddle_hit) begin
                hit_cnt <= hit_cnt + 2'd1;
                if (hit_cnt == 2'd3)
                    spd_x <= (spd_x + 11'd2 > SPX_MAX) ? SPX_MAX : spd_x + 11'd2;
            end
        end
    end
`else
    assign spd_x = SPX;
`endif

    ball_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)) u_hit_l (
        .cand_x     (cand_l),
        .cand_y     (cy),
        .pad_x      (P1X),
        .pad_y      ({2'b00, p1_y}),
        .hit        (hit_l),
        .upper_half (up_l)
    );

    ball_paddle_hit #(.BALL_SIZE(BALL_SIZE), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)) u_hit_r (
        .cand_x     (cand_r),
        .cand_y     (cy),
        .pad_x      (P2X),
        .pad_y      ({2'b00, p2_y}),
        .hit        (hit_r),
        .upper_half (up_r)
    );

    always_comb begin
        cx     = {1'b0, ball_x};
        cy     = {2'b00, ball_y};
        cand_l = (cx < spd_x) ? '0 : cx - spd_x;
        cand_r = cx + spd_x;

        sy_l = {2'b00, p1_y} + SRV_OFS;
        if (sy_l > Y_MAX) sy_l = Y_MAX;
        sy_r = {2'b00, p2_y} + SRV_OFS;
        if (sy_r > Y_MAX) sy_r = Y_MAX;

        if (dy == DIR_NEG) begin
            if (cy < SPY) begin
                ny  = '0;
                ndy = DIR_POS;
            end else begin
                ny  = cy - SPY;
                ndy = DIR_NEG;
            end
        end else if (cy + SPY > Y_MAX) begin
            ny  = Y_MAX;
            ndy = DIR_NEG;
        end else begin
            ny  = cy + SPY;
            ndy = DIR_POS;
        end

        // A paddle hit overrides the wall-derived dy and wins over a miss.
        nx         = cx;
        ndx        = dx;
        miss_l     = 1'b0;
        miss_r     = 1'b0;
        paddle_hit = 1'b0;
        if (dx == DIR_NEG) begin
            if (hit_l) begin
                nx         = P1_FACE;
                ndx        = DIR_POS;
                ndy        = up_l ? DIR_NEG : DIR_POS;
                paddle_hit = 1'b1;
            end else if (cx < spd_x) begin
                miss_l = 1'b1;
            end else begin
                nx = cand_l;
            end
        end else begin
            if (hit_r) begin
                nx         = P2_FACE;
                ndx        = DIR_NEG;
                ndy        = up_r ? DIR_NEG : DIR_POS;
                paddle_hit = 1'b1;
            end else if (cx + spd_x > X_MAX) begin
                miss_r = 1'b1;
            end else begin
                nx = cand_r;
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{nx[10], ny[10:9], sy_l[10:9], sy_r[10:9]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SERVE_R;
            ball_x    <= SRV_R_X;
            ball_y    <= Y_RST;
            dx        <= DIR_NEG;
            dy        <= DIR_POS;
            score_p1  <= '0;
            score_p2  <= '0;
            point_p1  <= 1'b0;
            point_p2  <= 1'b0;
            hold_cnt  <= '0;
            p2_scored <= 1'b0;
            serving   <= 1'b1;
            game_over <= 1'b0;
        end else begin
            point_p1 <= 1'b0;
            point_p2 <= 1'b0;
            case (state)
                SERVE_L: begin
                    if (p1_srv) begin
                        state   <= PLAY;
                        serving <= 1'b0;
                        dx      <= DIR_POS;
                        dy      <= DIR_POS;
                    end else if (frame_tick) begin
                        ball_x <= SRV_L_X;
                        ball_y <= sy_l[8:0];
                    end
                end
                SERVE_R: begin
                    if (p2_srv) begin
                        state   <= PLAY;
                        serving <= 1'b0;
                        dx      <= DIR_NEG;
                        dy      <= DIR_POS;
                    end else if (frame_tick) begin
                        ball_x <= SRV_R_X;
                        ball_y <= sy_r[8:0];
                    end
                end
                PLAY: begin
                    if (frame_tick) begin
                        ball_y <= ny[8:0];
                        dy     <= ndy;
                        if (miss_l) begin
                            point_p2  <= 1'b1;
                            score_p2  <= score_inc(score_p2);
                            p2_scored <= 1'b1;
                            hold_cnt  <= '0;
                            state     <= SCORED;
                        end else if (miss_r) begin
                            point_p1  <= 1'b1;
                            score_p1  <= score_inc(score_p1);
                            p2_scored <= 1'b0;
                            hold_cnt  <= '0;
                            state     <= SCORED;
                        end else begin
                            ball_x <= nx[9:0];
                            dx     <= ndx;
                        end
                    end
                end
                SCORED: begin
                    if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            hold_cnt <= '0;
                            if ((p2_scored ? score_p2 : score_p1) == WIN) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state   <= p2_scored ? SERVE_L : SERVE_R;
                                serving <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (p1_srv || p2_srv) begin
                        score_p1  <= '0;
                        score_p2  <= '0;
                        state     <= SERVE_R;
                        serving   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                default: begin
                    state   <= SERVE_R;
                    serving <= 1'b1;
                end
            endcase
        end
    end

endmodule
